align_reduce_buf: RTL and testbench

- Parametrised multi-channel successor to the fixed 4-bit reduce/slice register block.
- Per beat: takes CHANNELS lanes of WIDTH bits each, applies a per-beat slice mode, and computes a per-lane AND-reduction.
- Buffers results in a 2-entry FIFO with valid/ready on both sides.
- Keeps a saturating count of all-ones beats; sits between the input sampler and downstream status logic.

---
 rtl/align_reduce_buf.sv | 143 ++++++++++++++
 tb/tb_align_reduce_buf.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/align_reduce_buf.sv
// align_reduce_buf
//   Multi-lane beat transformer with a 2-entry output FIFO.
//   Each accepted beat carries CHANNELS lanes of WIDTH bits and a 2-bit slice
//   mode. Every lane is transformed according to that mode. The AND-reduction
//   of each untransformed lane is stored next to the transformed data. Beats
//   in which every lane is all-ones are counted in a saturating counter.
//
// Parameters
//   WIDTH    bits per lane (even, >= 2)
//   CHANNELS number of lanes (>= 1)
//   CNT_W    width of the all-ones beat counter (>= 1)
//
// Ports
//   clk       clock, all logic on posedge
//   rst       synchronous active-high reset
//   in_valid  input beat valid
//   in_ready  block can accept a beat (registered)
//   in_data   lane c = in_data[c*WIDTH +: WIDTH]
//   in_mode   slice mode, captured with in_data
//                0 pass, 1 invert, 2 swap halves, 3 duplicate low half
//   out_valid FIFO head is valid
//   out_ready downstream accepts the head
//   out_data  transformed lanes of the head beat
//   out_and   per-lane AND-reduction of the head beat's original lanes
//   cnt_clr   synchronous clear of ones_cnt (wins over an increment)
//   ones_cnt  saturating count of accepted all-ones beats
module align_reduce_buf #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [1:0]                in_mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_and,
  input  logic                      cnt_clr,
  output logic [CNT_W-1:0]          ones_cnt
);

  localparam int H  = WIDTH / 2;
  localparam int DW = CHANNELS * WIDTH;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic [WIDTH-1:0] lane_xform(input logic [WIDTH-1:0] x,
                                                  input logic [1:0]       mode);
    logic [WIDTH-1:0] r;
    case (mode)
      2'd0:    r = x;
      2'd1:    r = ~x;
      2'd2:    r = {x[H-1:0], x[WIDTH-1:H]};
      default: r = {x[H-1:0], x[H-1:0]};
    endcase
    return r;
  endfunction

  // Per-lane transform and reduction of the incoming beat
  logic [DW-1:0]       xform_data;
  logic [CHANNELS-1:0] lane_and;

  always_comb begin
    xform_data = '0;
    lane_and   = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      xform_data[c*WIDTH +: WIDTH] = lane_xform(in_data[c*WIDTH +: WIDTH], in_mode);
      lane_and[c]                  = &in_data[c*WIDTH +: WIDTH];
    end
  end

  // 2-entry FIFO storage
  logic [DW-1:0]       mem_data [2];
  logic [CHANNELS-1:0] mem_and  [2];
  logic                wr_ptr;
  logic                rd_ptr;
  logic [1:0]          count;
  logic [1:0]          count_nxt;
  logic                in_ready_r;

  logic push;
  logic pop;

  assign in_ready  = in_ready_r;
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready_r;
  assign pop       = out_valid && out_ready;

  assign out_data = mem_data[rd_ptr];
  assign out_and  = mem_and[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_data[0] <= '0;
      mem_data[1] <= '0;
      mem_and[0]  <= '0;
      mem_and[1]  <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
      in_ready_r  <= 1'b0;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= xform_data;
        mem_and[wr_ptr]  <= lane_and;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count_nxt;
      // Ready follows next-cycle occupancy, so a pop frees a slot one cycle
      // later with no combinational path from out_ready to in_ready.
      in_ready_r <= (count_nxt != 2'd2);
    end
  end

  // All-ones beat counter
  always_ff @(posedge clk) begin
    if (rst) begin
      ones_cnt <= '0;
    end else if (cnt_clr) begin
      ones_cnt <= '0;
    end else if (push && (&lane_and) && (ones_cnt != CNT_MAX)) begin
      ones_cnt <= ones_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_align_reduce_buf.sv
module tb_align_reduce_buf;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [1:0] in_mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] out_and;
  logic       cnt_clr;
  logic [7:0] ones_cnt;

  // Second instance with a 2-bit counter for saturation checks
  logic       in_ready2;
  logic       out_valid2;
  logic [7:0] out_data2;
  logic [1:0] out_and2;
  logic [1:0] ones_cnt2;

  int n_cmp = 0;
  int n_err = 0;

  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  align_reduce_buf #(.WIDTH(4), .CHANNELS(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_and(out_and),
    .cnt_clr(cnt_clr), .ones_cnt(ones_cnt)
  );

  align_reduce_buf #(.WIDTH(4), .CHANNELS(2), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid2),
    .out_ready(out_ready), .out_data(out_data2), .out_and(out_and2),
    .cnt_clr(cnt_clr), .ones_cnt(ones_cnt2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a head beat is taken at the coming posedge
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard_unexpected: got data=%0h and=%0b expected none",
                 out_data, out_and);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        if ({out_and, out_data} !== e) begin
          n_err++;
          $display("FAIL scoreboard_beat: got data=%0h and=%0b expected data=%0h and=%0b",
                   out_data, out_and, e[7:0], e[9:8]);
        end
      end
    end
  end

  // Present a beat and hold it until accepted; returns at posedge+1
  task automatic send(input logic [7:0] d, input logic [1:0] m,
                      input logic [7:0] ed, input logic [1:0] ea, input bit track);
    bit done = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        done = 1;
        if (track) exp_q.push_back({ea, ed});
      end
      @(posedge clk);
      #1;
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && out_valid === 1'b0) done = 1;
    end
    if (!done) check("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hFF;
    in_mode   = 2'd0;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;

    // Reset held 2 cycles with in_valid asserted
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_ones_cnt", ones_cnt, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_and", out_and, 0);
    check("rst_ones_cnt_sat", ones_cnt2, 0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);

    // Modes, back to back
    out_ready = 1'b1;
    send(8'hA5, 2'd0, 8'hA5, 2'b00, 1);
    send(8'hA5, 2'd1, 8'h5A, 2'b00, 1);
    send(8'hA5, 2'd2, 8'hA5, 2'b00, 1);
    send(8'hA5, 2'd3, 8'hA5, 2'b00, 1);
    send(8'h1E, 2'd2, 8'h4B, 2'b00, 1);
    send(8'h1E, 2'd3, 8'h5A, 2'b00, 1);
    send(8'h1E, 2'd1, 8'hE1, 2'b00, 1);
    idle();
    drain();
    check("modes_ones_cnt", ones_cnt, 0);

    // Backpressure
    out_ready = 1'b0;
    send(8'h11, 2'd0, 8'h11, 2'b00, 1);
    send(8'h22, 2'd0, 8'h22, 2'b00, 1);
    in_valid = 1'b1;
    in_data  = 8'h33;
    in_mode  = 2'd0;
    @(negedge clk);
    check("full_in_ready", in_ready, 0);
    check("full_out_data", out_data, 8'h11);
    @(posedge clk);
    #1;
    check("full_hold_data", out_data, 8'h11);
    check("full_hold_valid", out_valid, 1);
    out_ready = 1'b1;
    send(8'h33, 2'd0, 8'h33, 2'b00, 1);
    idle();
    drain();

    // Counter
    send(8'hFF, 2'd0, 8'hFF, 2'b11, 1);
    send(8'hFF, 2'd1, 8'h00, 2'b11, 1);
    send(8'hFF, 2'd3, 8'hFF, 2'b11, 1);
    send(8'hF0, 2'd0, 8'hF0, 2'b10, 1);
    idle();
    drain();
    check("cnt_three", ones_cnt, 3);
    cnt_clr = 1'b1;
    send(8'hFF, 2'd0, 8'hFF, 2'b11, 1);
    cnt_clr = 1'b0;
    idle();
    check("cnt_clr_wins", ones_cnt, 0);
    check("cnt_clr_wins_sat", ones_cnt2, 0);
    drain();

    // Saturation on the 2-bit counter
    send(8'hFF, 2'd0, 8'hFF, 2'b11, 1);
    check("sat_1", ones_cnt2, 1);
    send(8'hFF, 2'd0, 8'hFF, 2'b11, 1);
    check("sat_2", ones_cnt2, 2);
    send(8'hFF, 2'd0, 8'hFF, 2'b11, 1);
    check("sat_3", ones_cnt2, 3);
    send(8'hFF, 2'd0, 8'hFF, 2'b11, 1);
    check("sat_4", ones_cnt2, 3);
    send(8'hFF, 2'd0, 8'hFF, 2'b11, 1);
    check("sat_5", ones_cnt2, 3);
    idle();
    drain();
    check("wide_cnt_5", ones_cnt, 5);

    // Reset with two beats buffered; they must never be presented
    out_ready = 1'b0;
    send(8'h77, 2'd0, 8'h77, 2'b00, 0);
    send(8'h88, 2'd0, 8'h88, 2'b00, 0);
    idle();
    check("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_ones_cnt", ones_cnt, 0);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("mid_rst_still_empty", out_valid, 0);
    send(8'h3C, 2'd0, 8'h3C, 2'b00, 1);
    idle();
    drain();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
